// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Two-master (fetch/data) arbiter onto one memory port, with a
//            data-burst limiter, a slave timeout and pipeline stall requests.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_D_BURST = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // m0: instruction fetch (read only)
  input  logic                m0_req_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  output logic [DATA_W-1:0]   m0_rdata_o,
  output logic                m0_ack_o,
  // m1: load/store
  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_sel_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                m1_ack_o,
  output logic                err_o,
  // shared slave port
  output logic                s_req_o,
  output logic                s_we_o,
  output logic [DATA_W/8-1:0] s_sel_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  input  logic [DATA_W-1:0]   s_rdata_i,
  input  logic                s_ack_i,
  // pipeline stalls
  output logic                stallreq_if_o,
  output logic                stallreq_mem_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam int BC_W  = (MAX_D_BURST > 1) ? $clog2(MAX_D_BURST + 1) : 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [BC_W-1:0] C_BURST_MAX = BC_W'(MAX_D_BURST);
  localparam logic [TO_W-1:0] C_TO_LIMIT  = TO_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_owner;      // 0 = m0, 1 = m1
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [SEL_W-1:0]    r_sel;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_err;
  logic [DATA_W-1:0]   r_m0_rdata;
  logic [DATA_W-1:0]   r_m1_rdata;
  logic [BC_W-1:0]     r_burst_cnt;
  logic [TO_W-1:0]     r_to_cnt;

  logic                w_grant_m0;
  logic                w_grant_m1;
  logic                w_burst_full;
  logic [TO_W-1:0]     w_to_nxt;
  logic                w_to_hit;
  logic                w_timeout;

  assign w_burst_full = (r_burst_cnt == C_BURST_MAX);
  assign w_to_nxt     = r_to_cnt + 1'b1;

  // The counter holds completed no-ack BUSY cycles, so the limit is hit on the
  // TIMEOUT-th such cycle.
  generate
    if (TIMEOUT != 0) begin : g_timeout
      assign w_to_hit = (w_to_nxt == C_TO_LIMIT);
    end else begin : g_no_timeout
      assign w_to_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_m0  = 1'b0;
    w_grant_m1  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (m1_req_i && !(m0_req_i && w_burst_full)) begin
          w_grant_m1 = 1'b1;
        end else if (m0_req_i) begin
          w_grant_m0 = 1'b1;
        end
        if (w_grant_m0 || w_grant_m1) begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (s_ack_i) begin
          w_state_nxt = ST_RESP;
        end else if (w_to_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_owner     <= 1'b0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_wdata     <= '0;
      r_err       <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
      r_burst_cnt <= '0;
      r_to_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_to_cnt <= '0;
          r_err    <= 1'b0;
          if (w_grant_m1) begin
            r_owner <= 1'b1;
            r_addr  <= m1_addr_i;
            r_we    <= m1_we_i;
            r_sel   <= m1_sel_i;
            r_wdata <= m1_wdata_i;
            // Only data grants that make fetch wait count towards the limit
            if (!m0_req_i) begin
              r_burst_cnt <= '0;
            end else if (!w_burst_full) begin
              r_burst_cnt <= r_burst_cnt + 1'b1;
            end
          end else if (w_grant_m0) begin
            r_owner     <= 1'b0;
            r_addr      <= m0_addr_i;
            r_we        <= 1'b0;
            r_sel       <= '1;
            r_wdata     <= '0;
            r_burst_cnt <= '0;
          end else if (!m0_req_i) begin
            r_burst_cnt <= '0;
          end
        end
        ST_BUSY: begin
          if (s_ack_i) begin
            if (r_owner) begin
              r_m1_rdata <= s_rdata_i;
            end else begin
              r_m0_rdata <= s_rdata_i;
            end
          end else if (w_timeout) begin
            r_err <= 1'b1;
            if (r_owner) begin
              r_m1_rdata <= '0;
            end else begin
              r_m0_rdata <= '0;
            end
          end else if (TIMEOUT != 0) begin
            r_to_cnt <= w_to_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign s_req_o   = (r_state == ST_BUSY);
  assign s_we_o    = r_we;
  assign s_sel_o   = r_sel;
  assign s_addr_o  = r_addr;
  assign s_wdata_o = r_wdata;

  assign m0_rdata_o = r_m0_rdata;
  assign m1_rdata_o = r_m1_rdata;
  assign m0_ack_o   = (r_state == ST_RESP) && !r_owner;
  assign m1_ack_o   = (r_state == ST_RESP) && r_owner;
  assign err_o      = (r_state == ST_RESP) && r_err;

  assign stallreq_if_o  = m0_req_i & ~m0_ack_o;
  assign stallreq_mem_o = m1_req_i & ~m1_ack_o;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Directed self-checking bench for mem_bus_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst_i;
  logic        m0_req_i;
  logic [31:0] m0_addr_i;
  logic [31:0] m0_rdata_o;
  logic        m0_ack_o;
  logic        m1_req_i;
  logic        m1_we_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_addr_i;
  logic [31:0] m1_wdata_i;
  logic [31:0] m1_rdata_o;
  logic        m1_ack_o;
  logic        err_o;
  logic        s_req_o;
  logic        s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_addr_o;
  logic [31:0] s_wdata_o;
  logic [31:0] s_rdata_i;
  logic        s_ack_i;
  logic        stallreq_if_o;
  logic        stallreq_mem_o;

  int checks = 0;
  int errors = 0;

  // Slave model: acks on BUSY cycle number slv_wait (0 = first), returns slv_data
  logic [7:0]  slv_cnt;
  logic [7:0]  slv_wait;
  logic [31:0] slv_data;

  assign s_ack_i   = s_req_o && (slv_cnt == slv_wait);
  assign s_rdata_i = slv_data;

  always @(posedge clk) begin
    if (!rst_i) slv_cnt <= 8'd0;
    else        slv_cnt <= s_req_o ? slv_cnt + 8'd1 : 8'd0;
  end

  mem_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_D_BURST(4), .TIMEOUT(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_rdata_o(m0_rdata_o), .m0_ack_o(m0_ack_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i), .m1_addr_i(m1_addr_i),
    .m1_wdata_i(m1_wdata_i), .m1_rdata_o(m1_rdata_o), .m1_ack_o(m1_ack_o), .err_o(err_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_addr_o(s_addr_o),
    .s_wdata_o(s_wdata_o), .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i),
    .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_i = 1'b0; m0_req_i = 1'b0; m0_addr_i = '0; m1_req_i = 1'b0; m1_we_i = 1'b0;
    m1_sel_i = '0; m1_addr_i = '0; m1_wdata_i = '0; slv_wait = 8'd100; slv_data = '0;
    tick(); tick();
    checks++; if ({s_req_o, m0_ack_o, m1_ack_o, err_o} !== 4'b0000) begin errors++;
      $display("FAIL reset_outputs: got req/ack0/ack1/err=%b required 0000", {s_req_o, m0_ack_o, m1_ack_o, err_o}); end
    checks++; if ({m0_rdata_o, m1_rdata_o} !== 64'd0) begin errors++;
      $display("FAIL reset_rdata: got %h %h required 0 0", m0_rdata_o, m1_rdata_o); end
    // start an m1 access, then reset while it is in BUSY
    rst_i = 1'b1; m1_req_i = 1'b1; m1_addr_i = 32'h80; m1_sel_i = 4'hF;
    tick();
    checks++; if (s_req_o !== 1'b1) begin errors++;
      $display("FAIL reset_pre_busy: got s_req=%b required 1", s_req_o); end
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({s_req_o, m0_ack_o, m1_ack_o, err_o} !== 4'b0000) begin errors++;
        $display("FAIL reset_mid_busy[%0d]: got req/ack0/ack1/err=%b required 0000", i, {s_req_o, m0_ack_o, m1_ack_o, err_o}); end
    end
    rst_i = 1'b1; m1_req_i = 1'b0;
    tick();
    checks++; if ({s_req_o, m1_ack_o, m1_rdata_o} !== 34'd0) begin errors++;
      $display("FAIL reset_idle: got req=%b ack1=%b rdata1=%h required 0 0 0", s_req_o, m1_ack_o, m1_rdata_o); end
  endtask

  task automatic test_single_fetch;
    slv_wait = 8'd0; slv_data = 32'h00500093;
    m0_req_i = 1'b1; m0_addr_i = 32'h10;
    tick();
    checks++; if ({s_req_o, s_we_o, s_sel_o, s_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h10}) begin errors++;
      $display("FAIL fetch_busy: got req=%b we=%b sel=%h addr=%h required 1 0 f 00000010", s_req_o, s_we_o, s_sel_o, s_addr_o); end
    checks++; if ({m0_ack_o, stallreq_if_o} !== 2'b01) begin errors++;
      $display("FAIL fetch_busy_stall: got ack0=%b stall_if=%b required 0 1", m0_ack_o, stallreq_if_o); end
    tick();
    checks++; if ({m0_ack_o, m1_ack_o, err_o, s_req_o, stallreq_if_o} !== 5'b10000) begin errors++;
      $display("FAIL fetch_resp: got ack0/ack1/err/req/stall=%b required 10000", {m0_ack_o, m1_ack_o, err_o, s_req_o, stallreq_if_o}); end
    checks++; if (m0_rdata_o !== 32'h00500093) begin errors++;
      $display("FAIL fetch_rdata: got %h required 00500093", m0_rdata_o); end
    m0_req_i = 1'b0;
    tick();
    checks++; if ({m0_ack_o, s_req_o, m0_rdata_o} !== {2'b00, 32'h00500093}) begin errors++;
      $display("FAIL fetch_after: got ack0=%b req=%b rdata=%h required 0 0 00500093", m0_ack_o, s_req_o, m0_rdata_o); end
  endtask

  task automatic test_collision;
    slv_wait = 8'd0; slv_data = 32'h0BADF00D;
    m0_req_i = 1'b1; m0_addr_i = 32'h20;
    m1_req_i = 1'b1; m1_we_i = 1'b1; m1_sel_i = 4'hF; m1_addr_i = 32'h100; m1_wdata_i = 32'hDEADBEEF;
    tick();
    checks++; if ({s_req_o, s_we_o, s_addr_o, s_wdata_o} !== {2'b11, 32'h100, 32'hDEADBEEF}) begin errors++;
      $display("FAIL coll_m1_busy: got req=%b we=%b addr=%h wdata=%h required 1 1 00000100 deadbeef", s_req_o, s_we_o, s_addr_o, s_wdata_o); end
    checks++; if ({stallreq_if_o, stallreq_mem_o} !== 2'b11) begin errors++;
      $display("FAIL coll_stalls: got if=%b mem=%b required 1 1", stallreq_if_o, stallreq_mem_o); end
    tick();
    checks++; if ({m1_ack_o, m0_ack_o, err_o, stallreq_mem_o, stallreq_if_o} !== 5'b10001) begin errors++;
      $display("FAIL coll_m1_resp: got ack1/ack0/err/stall_mem/stall_if=%b required 10001", {m1_ack_o, m0_ack_o, err_o, stallreq_mem_o, stallreq_if_o}); end
    m1_req_i = 1'b0; m1_we_i = 1'b0;
    tick();
    checks++; if ({s_req_o, stallreq_if_o} !== 2'b01) begin errors++;
      $display("FAIL coll_idle: got req=%b stall_if=%b required 0 1", s_req_o, stallreq_if_o); end
    tick();
    checks++; if ({s_req_o, s_we_o, s_addr_o, s_wdata_o} !== {2'b10, 32'h20, 32'h0}) begin errors++;
      $display("FAIL coll_m0_busy: got req=%b we=%b addr=%h wdata=%h required 1 0 00000020 0", s_req_o, s_we_o, s_addr_o, s_wdata_o); end
    tick();
    checks++; if ({m0_ack_o, m1_ack_o, stallreq_if_o, m0_rdata_o} !== {3'b100, 32'h0BADF00D}) begin errors++;
      $display("FAIL coll_m0_resp: got ack0=%b ack1=%b stall_if=%b rdata=%h required 1 0 0 0badf00d", m0_ack_o, m1_ack_o, stallreq_if_o, m0_rdata_o); end
    m0_req_i = 1'b0;
    tick(); tick();
  endtask

  task automatic test_starvation;
    logic [31:0] exp_addr [6];
    exp_addr = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h40, 32'h200};
    slv_wait = 8'd0; slv_data = 32'hA5A50001;
    m0_req_i = 1'b1; m0_addr_i = 32'h40;
    m1_req_i = 1'b1; m1_we_i = 1'b0; m1_sel_i = 4'h3; m1_addr_i = 32'h200;
    for (int g = 0; g < 6; g++) begin
      for (int w = 0; w < 10 && !s_req_o; w++) tick();
      checks++; if (s_req_o !== 1'b1 || s_addr_o !== exp_addr[g]) begin errors++;
        $display("FAIL starve_grant[%0d]: got req=%b addr=%h required 1 %h", g, s_req_o, s_addr_o, exp_addr[g]); end
      tick();
    end
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    tick(); tick();
  endtask

  task automatic test_timeout;
    slv_wait = 8'd100;
    m1_req_i = 1'b1; m1_we_i = 1'b0; m1_sel_i = 4'hF; m1_addr_i = 32'h300;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++; if ({s_req_o, m1_ack_o, err_o} !== 3'b100) begin errors++;
        $display("FAIL timeout_busy[%0d]: got req/ack1/err=%b required 100", k, {s_req_o, m1_ack_o, err_o}); end
    end
    tick();
    checks++; if ({m1_ack_o, err_o, m0_ack_o, s_req_o, m1_rdata_o} !== {4'b1100, 32'h0}) begin errors++;
      $display("FAIL timeout_resp: got ack1=%b err=%b ack0=%b req=%b rdata=%h required 1 1 0 0 0", m1_ack_o, err_o, m0_ack_o, s_req_o, m1_rdata_o); end
    m1_req_i = 1'b0;
    tick();
    checks++; if ({m1_ack_o, err_o} !== 2'b00) begin errors++;
      $display("FAIL timeout_after: got ack1=%b err=%b required 0 0", m1_ack_o, err_o); end
    slv_wait = 8'd0; slv_data = 32'hCAFEF00D;
    m0_req_i = 1'b1; m0_addr_i = 32'h44;
    tick(); tick();
    checks++; if ({m0_ack_o, err_o, m0_rdata_o} !== {2'b10, 32'hCAFEF00D}) begin errors++;
      $display("FAIL timeout_next_fetch: got ack0=%b err=%b rdata=%h required 1 0 cafef00d", m0_ack_o, err_o, m0_rdata_o); end
    m0_req_i = 1'b0;
    tick();
  endtask

  task automatic test_ack_on_timeout;
    slv_wait = 8'd7; slv_data = 32'h12345678;
    m1_req_i = 1'b1; m1_we_i = 1'b0; m1_sel_i = 4'hF; m1_addr_i = 32'h304;
    for (int k = 1; k <= 8; k++) tick();
    checks++; if ({s_req_o, m1_ack_o} !== 2'b10) begin errors++;
      $display("FAIL ackto_busy8: got req=%b ack1=%b required 1 0", s_req_o, m1_ack_o); end
    tick();
    checks++; if ({m1_ack_o, err_o, m1_rdata_o} !== {2'b10, 32'h12345678}) begin errors++;
      $display("FAIL ackto_resp: got ack1=%b err=%b rdata=%h required 1 0 12345678", m1_ack_o, err_o, m1_rdata_o); end
    m1_req_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_collision();
    test_starvation();
    test_timeout();
    test_ack_on_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
